// File: rtl/reg_file_if.sv
// Read-port bundle between decode (client) and the register file (server).
// The client drives the address; the server returns the value combinationally.
interface regfile_read_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  logic [$clog2(NREGS)-1:0] addr;
  logic [XLEN-1:0]          val;

  modport Server (input addr, output val);
  modport Client (output addr, input val);
endinterface

// File: rtl/reg_file.sv
// Architectural integer register file: two combinational read ports, one writeback
// port and a per-register pending-write scoreboard. Optional macro REGFILE_BYPASS_EN.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_read_if.Server           read0,
  regfile_read_if.Server           read1,
  input  logic                     wbValid,
  input  logic [$clog2(NREGS)-1:0] wbRd,
  input  logic [XLEN-1:0]          wbVal,
  input  logic                     rsvValid,
  input  logic [$clog2(NREGS)-1:0] rsvRd,
  output logic                     busy0,
  output logic                     busy1
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy;
  logic [NREGS-1:1] busyNext;

  logic             wbHit;
  logic             rsvHit;
  logic [XLEN-1:0]  val0;
  logic [XLEN-1:0]  val1;
  logic             pend0;
  logic             pend1;

  assign wbHit  = wbValid  && (wbRd  != '0);
  assign rsvHit = rsvValid && (rsvRd != '0);

  // Clear before set so a same-cycle release and reserve leaves the newer producer pending.
  always_comb begin
    busyNext = busy;
    if (wbHit) begin
      busyNext[wbRd] = 1'b0;
    end
    if (rsvHit) begin
      busyNext[rsvRd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wbHit) begin
        regs[wbRd] <= wbVal;
      end
      busy <= busyNext;
    end
  end

  always_comb begin
    val0  = '0;
    pend0 = 1'b0;
    if (read0.addr != '0) begin
      val0  = regs[read0.addr];
      pend0 = busy[read0.addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (wbHit && (wbRd == read0.addr)) begin
      val0  = wbVal;
      pend0 = 1'b0;
    end
`endif
  end

  always_comb begin
    val1  = '0;
    pend1 = 1'b0;
    if (read1.addr != '0) begin
      val1  = regs[read1.addr];
      pend1 = busy[read1.addr];
    end
`ifdef REGFILE_BYPASS_EN
    if (wbHit && (wbRd == read1.addr)) begin
      val1  = wbVal;
      pend1 = 1'b0;
    end
`endif
  end

  assign read0.val = val0;
  assign read1.val = val1;
  assign busy0     = pend0;
  assign busy1     = pend1;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed test-plan cases then randomized traffic,
// checked against an array model of the architectural register state.
module tb_reg_file;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wbValid = 1'b0;
  logic [4:0]      wbRd = '0;
  logic [31:0]     wbVal = '0;
  logic            rsvValid = 1'b0;
  logic [4:0]      rsvRd = '0;
  logic            busy0;
  logic            busy1;

  regfile_read_if #(.XLEN(XLEN), .NREGS(NREGS)) rp0 ();
  regfile_read_if #(.XLEN(XLEN), .NREGS(NREGS)) rp1 ();

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .read0    (rp0),
    .read1    (rp1),
    .wbValid  (wbValid),
    .wbRd     (wbRd),
    .wbVal    (wbVal),
    .rsvValid (rsvValid),
    .rsvRd    (rsvRd),
    .busy0    (busy0),
    .busy1    (busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] v0;
    logic [31:0] v1;
    bit          b0;
    bit          b1;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] mRegs [NREGS];
  bit          mBusy [NREGS];

  function automatic logic [31:0] expVal(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : mRegs[a];
`ifdef REGFILE_BYPASS_EN
    if (wbValid && wbRd != 0 && wbRd == a) v = wbVal;
`endif
    return v;
  endfunction

  function automatic bit expBusy(input logic [4:0] a);
    bit b;
    b = (a == 0) ? 1'b0 : mBusy[a];
`ifdef REGFILE_BYPASS_EN
    if (wbValid && wbRd != 0 && wbRd == a) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic check(input string name, input logic [4:0] a, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=%0d got=%h want=%h t=%0t", name, a, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, queue expected read-port response, then advance the model.
  task automatic cyc(input bit r, input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                     input bit rv, input logic [4:0] rr,
                     input logic [4:0] a0, input logic [4:0] a1);
    exp_t e;
    rst = r; wbValid = wv; wbRd = wr; wbVal = wd;
    rsvValid = rv; rsvRd = rr;
    rp0.addr = a0; rp1.addr = a1;
    e.chk = !r;
    e.a0 = a0; e.a1 = a1;
    e.v0 = expVal(a0); e.v1 = expVal(a1);
    e.b0 = expBusy(a0); e.b1 = expBusy(a1);
    sbq.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREGS; i++) begin
        mRegs[i] = '0;
        mBusy[i] = 1'b0;
      end
    end else begin
      if (wv && wr != 0) begin
        mRegs[wr] = wd;
        mBusy[wr] = 1'b0;
      end
      if (rv && rr != 0) mBusy[rr] = 1'b1;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          check("val0",  e.a0, rp0.val, e.v0);
          check("busy0", e.a0, {31'b0, busy0}, {31'b0, e.b0});
          check("val1",  e.a1, rp1.val, e.v1);
          check("busy1", e.a1, {31'b0, busy1}, {31'b0, e.b1});
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] w, rr;
    rp0.addr = '0;
    rp1.addr = '0;
    for (int i = 0; i < NREGS; i++) begin
      mRegs[i] = 32'hFFFF_FFFF;
      mBusy[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NREGS; i++) cyc(0, 0, 0, 0, 0, 0, 5'(i), 5'(NREGS - 1 - i));

    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
    cyc(0, 0, 0, 0, 0, 0, 5, 5);
    cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 7, 0, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 7);
    cyc(0, 1, 7, 32'h55, 0, 0, 7, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 7);

    cyc(0, 0, 0, 0, 1, 3, 3, 3);
    cyc(0, 1, 3, 32'h3333_0003, 1, 3, 3, 3);
    cyc(0, 0, 0, 0, 0, 0, 3, 3);

    cyc(0, 1, 9, 32'h0000_0009, 0, 0, 0, 0);
    cyc(0, 1, 9, 32'hA5A5A5A5, 0, 0, 9, 1);
    cyc(0, 0, 0, 0, 0, 0, 9, 9);

    cyc(0, 1, 4, 32'h4444, 1, 4, 4, 4);
    cyc(0, 0, 0, 0, 1, 4, 4, 4);
    cyc(1, 1, 4, 32'h9999, 1, 4, 4, 4);
    cyc(0, 0, 0, 0, 0, 0, 4, 4);

    for (int n = 0; n < 3000; n++) begin
      w  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, w, $urandom,
          $urandom_range(0, 1) == 1, rr,
          5'($urandom_range(0, 8)), ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 8)));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
